// File: rtl/alu_pipe.sv
// alu_pipe: two-stage regfile/ALU execute; issue -> result/writeback 2 cycles, no output backpressure.
// ALU_PIPE_FORWARD_EN forwards the EX result on a hazard; otherwise in_ready drops for one cycle and a bubble enters EX.
module alu_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int A0_INDEX      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic [2:0]               ALUCtrl,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     eq,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(A0_INDEX);

  typedef struct packed {
    logic                     vld;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     wr;
    logic [2:0]               ctrl;
    logic [DATA_WIDTH-1:0]    op1;
    logic [DATA_WIDTH-1:0]    op2;
  } ex_t;

  ex_t                   ex_q;
  ex_t                   ex_d;
  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] rd1_dat;
  logic [DATA_WIDTH-1:0] rd2_dat;
  logic                  ex_wb;
  logic                  haz1;
  logic                  haz2;

  always_comb begin
    alu_res = '0;
    case (ex_q.ctrl)
      3'b000: alu_res = ex_q.op1 + ex_q.op2;
      3'b001: alu_res = ex_q.op1 - ex_q.op2;
      3'b010: alu_res = ex_q.op1 & ex_q.op2;
      3'b011: alu_res = ex_q.op1 | ex_q.op2;
      3'b100: alu_res = ex_q.op1 ^ ex_q.op2;
      3'b101: alu_res = ex_q.op1 << ex_q.op2[SHW-1:0];
      3'b110: alu_res = ex_q.op1 >> ex_q.op2[SHW-1:0];
      default: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(ex_q.op1) < $signed(ex_q.op2))};
    endcase
  end

  // An EX instruction only counts as a producer if it will actually write a non-zero rd.
  assign ex_wb = ex_q.vld && ex_q.wr && (ex_q.rd != '0);
  assign haz1  = ex_wb && (ex_q.rd == rs1);
  assign haz2  = ex_wb && !ALUsrc && (ex_q.rd == rs2);

  assign rd1_dat = (rs1 == '0) ? '0 : regs[rs1];
  assign rd2_dat = (rs2 == '0) ? '0 : regs[rs2];

  always_comb begin
    ex_d      = '0;
    ex_d.vld  = in_valid && in_ready;
    ex_d.rd   = rd;
    ex_d.wr   = RegWrite;
    ex_d.ctrl = ALUCtrl;
`ifdef ALU_PIPE_FORWARD_EN
    in_ready  = 1'b1;
    ex_d.op1  = haz1 ? alu_res : rd1_dat;
    ex_d.op2  = ALUsrc ? ImmOp : (haz2 ? alu_res : rd2_dat);
`else
    in_ready  = !(in_valid && (haz1 || haz2));
    ex_d.op1  = rd1_dat;
    ex_d.op2  = ALUsrc ? ImmOp : rd2_dat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      eq        <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      ex_q      <= ex_d;
      out_valid <= ex_q.vld;
      if (ex_q.vld) begin
        result <= alu_res;
        eq     <= (ex_q.op1 == ex_q.op2);
      end
      if (ex_wb) regs[ex_q.rd] <= alu_res;
    end
  end

  assign a0 = regs[A0_IDX];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: architectural model (in-order, results retire 2 cycles after accept) plus directed literal checks.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ALUsrc;
  logic [2:0]  ALUCtrl;
  logic [31:0] ImmOp;
  logic        out_valid;
  logic [31:0] result;
  logic        eq;
  logic [31:0] a0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
    .ALUCtrl(ALUCtrl), .ImmOp(ImmOp), .out_valid(out_valid), .result(result),
    .eq(eq), .a0(a0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ALU_PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] res;
    logic        eqv;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mreg [32];   // architectural state: every accepted instruction applied
  logic [31:0] rreg [32];   // retired state: what the DUT array must hold now
  logic [31:0] ret_log [1024];
  logic        eq_log  [1024];
  logic        ov_log  [1024];
  logic [31:0] a0_log  [1024];
  int          last_cyc = -10;
  logic [4:0]  last_rd;
  logic        last_wr;

  always @(negedge clk) begin
    if (cyc < 1024) begin
      ret_log[cyc] = result;
      eq_log[cyc]  = eq;
      ov_log[cyc]  = out_valid;
      a0_log[cyc]  = a0;
    end
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 32; i++) begin
        mreg[i] = '0;
        rreg[i] = '0;
      end
      last_cyc = -10;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_a0", a0, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    end else begin
      logic        exp_v;
      logic [31:0] exp_r;
      logic        exp_e;
      exp_v = 1'b0;
      exp_r = '0;
      exp_e = 1'b0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        ent_t e;
        e = q.pop_front();
        exp_v = 1'b1;
        exp_r = e.res;
        exp_e = e.eqv;
        if (e.wr && e.rd != 0) rreg[e.rd] = e.res;
      end
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      if (exp_v) begin
        chk("result", result, exp_r);
        chk("eq", {31'b0, eq}, {31'b0, exp_e});
      end
      chk("a0", a0, rreg[10]);
      if (in_valid) begin
        logic haz;
        haz = (last_cyc == cyc - 1) && last_wr && (last_rd != 0) &&
              ((last_rd == rs1) || (!ALUsrc && last_rd == rs2));
        chk("in_ready", {31'b0, in_ready}, {31'b0, FWD ? 1'b1 : !haz});
      end
      if (in_valid && in_ready) begin
        ent_t        e;
        logic [31:0] o1, o2;
        o1 = mreg[rs1];
        o2 = ALUsrc ? ImmOp : mreg[rs2];
        e.cyc = cyc + 2;
        e.rd  = rd;
        e.wr  = RegWrite;
        e.res = alu_m(ALUCtrl, o1, o2);
        e.eqv = (o1 == o2);
        if (RegWrite && rd != 0) mreg[rd] = e.res;
        q.push_back(e);
        last_cyc = cyc;
        last_rd  = rd;
        last_wr  = RegWrite;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic wr, input logic src, input logic [2:0] op,
                       input logic [31:0] imm, output int ncyc, output int stalls);
    bit got;
    got    = 1'b0;
    stalls = 0;
    ncyc   = 0;
    rs1 = r1; rs2 = r2; rd = d; RegWrite = wr; ALUsrc = src; ALUCtrl = op; ImmOp = imm;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ncyc = cyc;
        got  = 1'b1;
        @(posedge clk); #1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_ret(input string nm, input int c, input logic [31:0] v);
    chk({nm, "_valid"}, {31'b0, ov_log[c]}, 32'd1);
    chk(nm, ret_log[c], v);
  endtask

  int nc [24];
  int st;
  int st_sum;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    RegWrite = 1'b0; ALUsrc = 1'b0; ALUCtrl = '0; ImmOp = '0;
    idle(3);
    rst_n = 1'b1;
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_a0", a0, 32'd0);

    // independent back-to-back
    issue(0, 0, 1, 1, 1, 3'd0, 32'd7, nc[0], st); st_sum = st;
    issue(0, 0, 2, 1, 1, 3'd0, 32'd3, nc[1], st); st_sum += st;
    idle(3);
    chk("indep_stalls", st_sum, 0);
    chk("indep_gap", nc[1] - nc[0], 1);
    expect_ret("indep_r1", nc[0] + 2, 32'd7);
    expect_ret("indep_r2", nc[1] + 2, 32'd3);

    // dependent pair on a0
    issue(0, 0, 10, 1, 1, 3'd0, 32'd5, nc[2], st);
    issue(10, 10, 10, 1, 0, 3'd0, 32'd0, nc[3], st);
    idle(3);
    chk("dep_gap", nc[3] - nc[2], FWD ? 1 : 2);
    expect_ret("dep_r1", nc[2] + 2, 32'd5);
    expect_ret("dep_r2", nc[3] + 2, 32'd10);
    chk("dep_a0_first", a0_log[nc[2] + 2], 32'd5);
    chk("dep_a0_second", a0_log[nc[3] + 2], 32'd10);
    if (!FWD) chk("dep_bubble", {31'b0, ov_log[nc[2] + 3]}, 32'd0);

    // operations and boundaries
    issue(0, 0, 3, 1, 1, 3'd0, 32'hFFFF_FFFF, nc[4], st);
    issue(3, 0, 4, 1, 1, 3'd0, 32'd1, nc[5], st);
    issue(0, 0, 5, 1, 1, 3'd0, 32'd1, nc[6], st);
    issue(5, 0, 6, 1, 1, 3'd5, 32'd31, nc[7], st);
    issue(6, 0, 7, 1, 1, 3'd6, 32'd31, nc[8], st);
    issue(3, 0, 8, 1, 1, 3'd7, 32'd1, nc[9], st);
    issue(0, 0, 9, 1, 1, 3'd0, 32'd3, nc[10], st);
    issue(9, 0, 11, 1, 1, 3'd1, 32'd5, nc[11], st);
    issue(3, 0, 12, 1, 1, 3'd2, 32'h0000_0F0F, nc[12], st);
    issue(6, 0, 13, 1, 1, 3'd3, 32'd1, nc[13], st);
    issue(3, 0, 14, 1, 1, 3'd4, 32'h0000_00FF, nc[14], st);
    issue(6, 5, 18, 1, 0, 3'd7, 32'd0, nc[15], st);
    issue(5, 6, 19, 1, 0, 3'd7, 32'd0, nc[16], st);
    idle(3);
    expect_ret("wrap_add", nc[5] + 2, 32'd0);
    expect_ret("sll31", nc[7] + 2, 32'h8000_0000);
    expect_ret("srl31", nc[8] + 2, 32'd1);
    expect_ret("slt_neg1_lt_1", nc[9] + 2, 32'd1);
    expect_ret("sub_3_5", nc[11] + 2, 32'hFFFF_FFFE);
    expect_ret("and", nc[12] + 2, 32'h0000_0F0F);
    expect_ret("or", nc[13] + 2, 32'h8000_0001);
    expect_ret("xor", nc[14] + 2, 32'hFFFF_FF00);
    expect_ret("slt_min_lt_1", nc[15] + 2, 32'd1);
    expect_ret("slt_1_lt_min", nc[16] + 2, 32'd0);

    // x0 writes dropped, no hazard from rd=0, eq flag
    issue(0, 0, 0, 1, 1, 3'd0, 32'd9, nc[17], st);
    issue(0, 0, 15, 1, 0, 3'd0, 32'd0, nc[18], st);
    chk("x0_no_stall", nc[18] - nc[17], 1);
    issue(0, 0, 16, 1, 1, 3'd0, 32'd4, nc[19], st);
    issue(16, 0, 20, 0, 1, 3'd0, 32'd4, nc[20], st);
    issue(16, 0, 20, 0, 1, 3'd0, 32'd5, nc[21], st);
    idle(3);
    expect_ret("x0_read", nc[18] + 2, 32'd0);
    chk("eq_true", {31'b0, eq_log[nc[20] + 2]}, 32'd1);
    chk("eq_false", {31'b0, eq_log[nc[21] + 2]}, 32'd0);
    expect_ret("eq_sum", nc[21] + 2, 32'd9);

    // reset while an a0 write sits in EX
    chk("pre_rst_a0", a0, 32'd10);
    issue(0, 0, 10, 1, 1, 3'd0, 32'd3, nc[22], st);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("rst_ex_a0", a0, 32'd0);
    chk("rst_ex_out_valid", {31'b0, ov_log[nc[22] + 2]}, 32'd0);

    // regfile cleared by reset
    issue(5, 0, 17, 1, 1, 3'd0, 32'd0, nc[23], st);
    idle(3);
    expect_ret("x5_after_rst", nc[23] + 2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
